logo_scroll_painter: RTL
========================

// Module: logo_scroll_painter
// PURPOSE
//   Pipelined VGA logo painter: renders a GLYPHS-long string of rectangle-built letters at
//   (BASE_X+delt, BASE_Y) and flags pixels that fall inside any glyph rectangle.
//   Owns its own horizontal bounce-scroll offset, stepped once per frame.
//   Sits between the VGA timing generator (x, y, de, frame_tick) and the colour mux.
// PARAMETERS
//   X_W         11   coordinate / offset width (bits)
//   GLYPHS      4    letters in the string
//   RECTS       3    rectangles per glyph (unused slots have w=0)
//   PITCH_LOG2  5    glyph cell width = 2**PITCH_LOG2 pixels
//   BASE_X      500  left edge of glyph 0 when delt=0
//   BASE_Y      550  top edge of the string
//   CELL_H      48   glyph cell height (pixels)
//   SCROLL_MAX  200  delt upper bound; lower bound is 0
//   STEP        2    pixels moved per frame_tick
//   BLINK_FRAMES 30  frames per blink half-period (BLINK_EN only)
// PORTS
//   clk         in   1            pixel clock
//   rst         in   1            asynchronous reset, active-low
//   x, y        in   X_W          current pixel coordinate
//   de          in   1            pixel valid (display enable)
//   frame_tick  in   1            one-cycle pulse per frame (start of vblank)
//   run         in   1            1 = scrolling, 0 = hold offset
//   text        in   GLYPHS*5     glyph codes, glyph 0 in [4:0]; code 0 = blank
//   hit         out  1            pixel inside logo (registered)
//   hit_valid   out  1            de delayed to align with hit
//   delt        out  X_W          current scroll offset
// BEHAVIOUR
//   Reset (async, rst=0): hit=0, hit_valid=0, delt=0, FSM=RIGHT, pipeline cleared, blink visible.
//   Pipeline, latency 2 clk from (x,y,de) to (hit,hit_valid); throughput one pixel/clk:
//   - S1: relx = x - (BASE_X+delt), rely = y - BASE_Y (X_W-bit, wrap on underflow);
//     in_band = relx < GLYPHS<<PITCH_LOG2 && rely < CELL_H (unsigned; underflow -> outside);
//     gidx = relx>>PITCH_LOG2, lx = relx[PITCH_LOG2-1:0], ly = rely; register with de.
//   - S2: code = text[gidx*5 +: 5]; ROM gives RECTS (rx,ry,w,h); rect hit iff
//     lx>=rx && lx<rx+w && ly>=ry && ly<ry+h; hit = in_band & de & OR(rect hits) & visible.
//   - hit is 0 whenever hit_valid is 0.
//   Scroll FSM, evaluated only on frame_tick=1:
//   - RIGHT: delt >= SCROLL_MAX-STEP -> delt=SCROLL_MAX, go LEFT; else delt+=STEP.
//   - LEFT:  delt <= STEP -> delt=0, go RIGHT; else delt-=STEP.
//   - PAUSE: entered from RIGHT/LEFT when run=0 (offset held, direction saved);
//     returns to saved direction when run=1; the first tick after resume moves.
//   - run sampled every clk; run=0 with a tick in the same cycle: no move.
//   - tick and de in the same cycle: S1 uses the pre-update delt (new delt visible next clk).
//   - Code >= number of ROM entries renders as blank; gidx >= GLYPHS is impossible once in_band.
// CONFIGURATION
//   BLINK_EN defined: frame counter counts frame_ticks; visible toggles every BLINK_FRAMES
//     ticks (independent of run); reset -> visible=1, counter=0.
//   BLINK_EN undefined: visible tied to 1, no counter logic.
// STRUCTURE
//   Shared package/header logo_pkg: glyph code constants (G_BLANK=0, G_J, G_M, ...),
//     rectangle table contents, FSM state encodings (RIGHT, LEFT, PAUSE).
//   Sub-module glyph_rect_rom: combinational code -> RECTS x {rx,ry,w,h}; J entry =
//     (10,0,20,5),(20,0,5,40),(10,40,10,5).
//   Top holds pipeline regs, FSM, blink counter, and RECTS parallel comparators.
// TESTING
//   1 reset: rst low mid-frame with de=1 -> hit=0, hit_valid=0, delt=0 immediately; next 2 clk stay 0.
//   2 latency: text={0,0,0,G_J}, delt=0, x=520,y=560,de=1 -> hit=1 exactly 2 clk later;
//     x=509 -> hit=0; x=530,y=590 -> hit=0 (outside rects).
//   3 bounce: run=1, 101 ticks from reset -> delt 2,4..200 then 198; at delt=200 FSM=LEFT.
//   4 pause: run=0 at delt=40, 5 ticks -> delt stays 40; run=1, next tick -> 42 (RIGHT kept).
//   5 tick+pixel same clk at delt=0, x=520,y=560 -> hit=1 (old offset); next pixel uses delt=2.
//   6 BLINK_EN: BLINK_FRAMES=3, J pixel driven every frame -> hit pattern 1,1,1,0,0,0,1 per frame.

Source files
------------

// File: rtl/logo_pkg.sv
// Shared definitions for the logo painter.
//   - glyph codes (G_BLANK, G_J, G_M) and ROM entry count
//   - rectangle record type and per-glyph rectangle sets
//   - scroll FSM state encoding
// Optional feature macro used by the top: BLINK_EN.
package logo_pkg;

  localparam int N_RECTS        = 3;
  localparam int RECT_W         = 6;
  localparam int N_GLYPH_CODES  = 3;

  localparam logic [4:0] G_BLANK = 5'd0;
  localparam logic [4:0] G_J     = 5'd1;
  localparam logic [4:0] G_M     = 5'd2;

  typedef struct packed {
    logic [RECT_W-1:0] rx;
    logic [RECT_W-1:0] ry;
    logic [RECT_W-1:0] w;
    logic [RECT_W-1:0] h;
  } rect_t;

  typedef rect_t [N_RECTS-1:0] rect_set_t;

  // Element [0] is the first rectangle of each glyph.
  localparam rect_t J_R0 = '{6'd10, 6'd0,  6'd20, 6'd5};
  localparam rect_t J_R1 = '{6'd20, 6'd0,  6'd5,  6'd40};
  localparam rect_t J_R2 = '{6'd10, 6'd40, 6'd10, 6'd5};
  localparam rect_set_t J_RECTS = {J_R2, J_R1, J_R0};

  localparam rect_t M_R0 = '{6'd0,  6'd0, 6'd5,  6'd48};
  localparam rect_t M_R1 = '{6'd27, 6'd0, 6'd5,  6'd48};
  localparam rect_t M_R2 = '{6'd5,  6'd0, 6'd22, 6'd6};
  localparam rect_set_t M_RECTS = {M_R2, M_R1, M_R0};

  typedef enum logic [1:0] {
    ST_RIGHT = 2'd0,
    ST_LEFT  = 2'd1,
    ST_PAUSE = 2'd2
  } scroll_state_e;

endpackage

// File: rtl/glyph_rect_rom.sv
// Combinational glyph ROM: glyph code -> set of rectangles {rx,ry,w,h}.
// Ports:
//   code_i   glyph code (5 bits)
//   rects_o  N_RECTS rectangles; unknown codes return all-zero (blank)
module glyph_rect_rom
  import logo_pkg::*;
(
  input  logic [4:0] code_i,
  output rect_set_t  rects_o
);

  always_comb begin
    rects_o = '0;
    case (code_i)
      G_J:     rects_o = J_RECTS;
      G_M:     rects_o = M_RECTS;
      default: rects_o = '0;
    endcase
  end

endmodule

// File: rtl/logo_scroll_painter.sv
// Pipelined VGA logo painter with bounce-scroll offset.
// Ports:
//   clk, rst (async, active-low)
//   x, y, de          pixel coordinate and display enable from the timing generator
//   frame_tick        one-cycle pulse per frame; steps the scroll FSM
//   run               1 = scroll, 0 = hold offset (pause)
//   text              glyph codes, glyph 0 in [4:0]
//   hit, hit_valid    registered logo flag and aligned enable (2 clk latency)
//   delt              current scroll offset
// Optional feature: define BLINK_EN to blank the logo every BLINK_FRAMES ticks.
//
// state    | meaning
// ST_RIGHT | offset increasing by STEP per tick
// ST_LEFT  | offset decreasing by STEP per tick
// ST_PAUSE | offset held; direction kept in saved_q
module logo_scroll_painter
  import logo_pkg::*;
#(
  parameter int X_W        = 11,
  parameter int GLYPHS     = 4,
  parameter int PITCH_LOG2 = 5,
  parameter int BASE_X     = 500,
  parameter int BASE_Y     = 550,
  parameter int CELL_H     = 48,
  parameter int SCROLL_MAX = 200,
  parameter int STEP       = 2
`ifdef BLINK_EN
  , parameter int BLINK_FRAMES = 30
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [X_W-1:0]        x,
  input  logic [X_W-1:0]        y,
  input  logic                  de,
  input  logic                  frame_tick,
  input  logic                  run,
  input  logic [GLYPHS*5-1:0]   text,
  output logic                  hit,
  output logic                  hit_valid,
  output logic [X_W-1:0]        delt
);

  localparam int GIDX_W = (GLYPHS > 1) ? $clog2(GLYPHS) : 1;
  localparam logic [X_W-1:0] BAND_W = X_W'(GLYPHS << PITCH_LOG2);
  localparam logic [X_W-1:0] SMAX   = X_W'(SCROLL_MAX);
  localparam logic [X_W-1:0] STEP_V = X_W'(STEP);

  scroll_state_e state_q, state_d, saved_q, saved_d, dir;
  logic [X_W-1:0] delt_q, delt_d;
  logic visible;

  // ---------------- scroll FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RIGHT;
      saved_q <= ST_RIGHT;
      delt_q  <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      delt_q  <= delt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    delt_d  = delt_q;
    dir     = (state_q == ST_PAUSE) ? saved_q : state_q;
    if (!run) begin
      if (state_q != ST_PAUSE) saved_d = state_q;
      state_d = ST_PAUSE;
    end else begin
      // Resuming in the same cycle as a tick moves immediately.
      state_d = dir;
      if (frame_tick) begin
        if (dir == ST_RIGHT) begin
          if (delt_q >= SMAX - STEP_V) begin
            delt_d  = SMAX;
            state_d = ST_LEFT;
          end else begin
            delt_d = delt_q + STEP_V;
          end
        end else begin
          if (delt_q <= STEP_V) begin
            delt_d  = '0;
            state_d = ST_RIGHT;
          end else begin
            delt_d = delt_q - STEP_V;
          end
        end
      end
    end
  end

  assign delt = delt_q;

  // ---------------- blink ----------------
`ifdef BLINK_EN
  localparam int BC_W = $clog2(BLINK_FRAMES + 1);
  logic [BC_W-1:0] blink_cnt_q;
  logic            visible_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      visible_q   <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        visible_q   <= ~visible_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BC_W'(1);
      end
    end
  end

  assign visible = visible_q;
`else
  assign visible = 1'b1;
`endif

  // ---------------- stage 1: relative coordinates ----------------
  // Underflow wraps to a large value, so a single unsigned compare covers both edges.
  logic [X_W-1:0] relx, rely;
  logic           in_band;

  assign relx    = x - (X_W'(BASE_X) + delt_q);
  assign rely    = y - X_W'(BASE_Y);
  assign in_band = (relx < BAND_W) && (rely < X_W'(CELL_H));

  logic                  s1_de_q, s1_band_q;
  logic [GIDX_W-1:0]     s1_gidx_q;
  logic [PITCH_LOG2-1:0] s1_lx_q;
  logic [X_W-1:0]        s1_ly_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_de_q   <= 1'b0;
      s1_band_q <= 1'b0;
      s1_gidx_q <= '0;
      s1_lx_q   <= '0;
      s1_ly_q   <= '0;
    end else begin
      s1_de_q   <= de;
      s1_band_q <= in_band;
      s1_gidx_q <= relx[PITCH_LOG2 +: GIDX_W];
      s1_lx_q   <= relx[PITCH_LOG2-1:0];
      s1_ly_q   <= rely;
    end
  end

  // ---------------- stage 2: glyph lookup and rectangle test ----------------
  logic [GLYPHS-1:0][4:0] text_a;
  logic [4:0]             code;
  rect_set_t              rects;
  logic [N_RECTS-1:0]     rect_hit;
  logic [X_W-1:0]         lx;
  logic                   hit_d;

  assign text_a = text;
  assign code   = text_a[s1_gidx_q];
  assign lx     = X_W'(s1_lx_q);

  glyph_rect_rom u_rom (
    .code_i  (code),
    .rects_o (rects)
  );

  for (genvar r = 0; r < N_RECTS; r++) begin : g_cmp
    logic [X_W-1:0] rx, ry;
    assign rx = X_W'(rects[r].rx);
    assign ry = X_W'(rects[r].ry);
    // w = 0 makes the x-range empty, so unused slots never hit.
    assign rect_hit[r] = (lx >= rx) && (lx < rx + X_W'(rects[r].w)) &&
                         (s1_ly_q >= ry) && (s1_ly_q < ry + X_W'(rects[r].h));
  end

  assign hit_d = s1_de_q & s1_band_q & (|rect_hit) & visible;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit       <= 1'b0;
      hit_valid <= 1'b0;
    end else begin
      hit       <= hit_d;
      hit_valid <= s1_de_q;
    end
  end

endmodule
